// File: rtl/video_timing_gen.sv
// video_timing_gen: programmable raster timing generator with built-in test patterns.
// Ports: clk/reset (synchronous, active-high), ce_pix pixel enable, pattern_sel[1:0];
//        hcnt/vcnt coordinates, hsync/vsync/csync/de/dout[23:0] {R,G,B}, frame_start strobe.
// Latency: every output is registered from next-state counters, so all are skew-free with hcnt/vcnt.
module video_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ce_pix,
    input  logic [1:0]  pattern_sel,
    output logic [11:0] hcnt,
    output logic [11:0] vcnt,
    output logic        hsync,
    output logic        vsync,
    output logic        csync,
    output logic        de,
    output logic [23:0] dout,
    output logic        frame_start
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam logic [11:0] H_LAST = 12'(H_TOTAL - 1);
    localparam logic [11:0] V_LAST = 12'(V_TOTAL - 1);

    // Region bounds kept at 13 bits so a 4096-wide boundary still compares correctly.
    localparam logic [12:0] H_ACT_END = 13'(H_ACTIVE);
    localparam logic [12:0] HS_BEGIN  = 13'(H_ACTIVE + H_FP);
    localparam logic [12:0] HS_END    = 13'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [12:0] V_ACT_END = 13'(V_ACTIVE);
    localparam logic [12:0] VS_BEGIN  = 13'(V_ACTIVE + V_FP);
    localparam logic [12:0] VS_END    = 13'(V_ACTIVE + V_FP + V_SYNC);

    // Bar width; guarded so a tiny H_ACTIVE still yields a legal counter.
    localparam int          BW      = (H_ACTIVE >= 8) ? (H_ACTIVE / 8) : 1;
    localparam logic [11:0] BW_LAST = 12'(BW - 1);

    logic [11:0] r_hcnt, r_vcnt;
    logic        r_hsync, r_vsync, r_csync, r_de, r_fs;
    logic [23:0] r_dout;
    logic [1:0]  r_pat;
    logic [2:0]  r_bar_idx;
    logic [11:0] r_bar_cnt;

    logic [11:0] w_hnext, w_vnext;
    logic        w_h_wrap, w_frame_entry;
    logic        w_de, w_hs_act, w_vs_act;
    logic [1:0]  w_pat;
    logic [2:0]  w_bar_idx;
    logic [11:0] w_bar_cnt;
    logic [23:0] w_bar_rgb, w_pix;

    // Next raster position and everything derived from it.
    always_comb begin
        w_h_wrap = (r_hcnt == H_LAST);
        w_hnext  = w_h_wrap ? 12'd0 : r_hcnt + 12'd1;
        w_vnext  = r_vcnt;
        if (w_h_wrap) begin
            w_vnext = (r_vcnt == V_LAST) ? 12'd0 : r_vcnt + 12'd1;
        end
        w_frame_entry = (w_hnext == 12'd0) && (w_vnext == 12'd0);

        // The pattern seen on the frame-entry edge is used immediately, not a pixel later.
        w_pat = w_frame_entry ? pattern_sel : r_pat;

        w_de     = ({1'b0, w_hnext} < H_ACT_END) && ({1'b0, w_vnext} < V_ACT_END);
        w_hs_act = ({1'b0, w_hnext} >= HS_BEGIN) && ({1'b0, w_hnext} < HS_END);
        w_vs_act = ({1'b0, w_vnext} >= VS_BEGIN) && ({1'b0, w_vnext} < VS_END);

        // Bar index: restarts each line, steps every BW pixels, sticks at the last bar.
        if (w_hnext == 12'd0) begin
            w_bar_idx = 3'd0;
            w_bar_cnt = 12'd0;
        end else if (r_bar_cnt == BW_LAST) begin
            w_bar_cnt = 12'd0;
            w_bar_idx = (r_bar_idx == 3'd7) ? 3'd7 : r_bar_idx + 3'd1;
        end else begin
            w_bar_cnt = r_bar_cnt + 12'd1;
            w_bar_idx = r_bar_idx;
        end

        case (w_bar_idx)
            3'd0:    w_bar_rgb = 24'hFFFFFF;
            3'd1:    w_bar_rgb = 24'hFFFF00;
            3'd2:    w_bar_rgb = 24'h00FFFF;
            3'd3:    w_bar_rgb = 24'h00FF00;
            3'd4:    w_bar_rgb = 24'hFF00FF;
            3'd5:    w_bar_rgb = 24'hFF0000;
            3'd6:    w_bar_rgb = 24'h0000FF;
            default: w_bar_rgb = 24'h000000;
        endcase

        case (w_pat)
            2'd1:    w_pix = w_bar_rgb;
            2'd2:    w_pix = ((w_hnext[3:0] == 4'd0) || (w_vnext[3:0] == 4'd0)) ? 24'hFFFFFF : 24'h000000;
            2'd3:    w_pix = {w_hnext[7:0], w_vnext[7:0], w_hnext[7:0] ^ w_vnext[7:0]};
            default: w_pix = 24'h000000;
        endcase
        if (!w_de) begin
            w_pix = 24'h000000;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_hcnt    <= H_LAST;
            r_vcnt    <= V_LAST;
            r_de      <= 1'b0;
            r_hsync   <= ~HS_POL;
            r_vsync   <= ~VS_POL;
            r_csync   <= 1'b1;
            r_dout    <= 24'h000000;
            r_fs      <= 1'b0;
            r_pat     <= 2'd0;
            r_bar_idx <= 3'd0;
            r_bar_cnt <= 12'd0;
        end else begin
            // frame_start self-clears even while the pixel enable is low.
            r_fs <= 1'b0;
            if (ce_pix) begin
                r_hcnt    <= w_hnext;
                r_vcnt    <= w_vnext;
                r_de      <= w_de;
                r_hsync   <= w_hs_act ^ ~HS_POL;
                r_vsync   <= w_vs_act ^ ~VS_POL;
                r_csync   <= ~(w_hs_act ^ w_vs_act);
                r_dout    <= w_pix;
                r_fs      <= w_frame_entry;
                r_pat     <= w_pat;
                r_bar_idx <= w_bar_idx;
                r_bar_cnt <= w_bar_cnt;
            end
        end
    end

    assign hcnt        = r_hcnt;
    assign vcnt        = r_vcnt;
    assign hsync       = r_hsync;
    assign vsync       = r_vsync;
    assign csync       = r_csync;
    assign de          = r_de;
    assign dout        = r_dout;
    assign frame_start = r_fs;

endmodule

// File: tb/tb_video_timing_gen.sv
// tb_video_timing_gen: three configurations of video_timing_gen driven by shared stimulus.
// Config 0 default VGA, config 1 active-high syncs with a 7-line frame, config 2 a small raster.
// A linear-pixel-index reference model supplies expected outputs for the randomized run.
module tb_video_timing_gen;
    localparam int P_HA  [3] = '{640, 640, 32};
    localparam int P_HFP [3] = '{16, 16, 4};
    localparam int P_HS  [3] = '{96, 96, 8};
    localparam int P_HBP [3] = '{48, 48, 4};
    localparam int P_VA  [3] = '{480, 4, 8};
    localparam int P_VFP [3] = '{10, 1, 2};
    localparam int P_VS  [3] = '{2, 1, 2};
    localparam int P_VBP [3] = '{33, 1, 3};
    localparam bit P_HSP [3] = '{1'b0, 1'b1, 1'b0};
    localparam bit P_VSP [3] = '{1'b0, 1'b1, 1'b0};
    localparam logic [23:0] BARS [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                         24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       ce_pix = 1'b0;
    logic [1:0] pattern_sel = 2'd0;

    wire [2:0][11:0] hc, vc;
    wire [2:0][23:0] dout;
    wire [2:0]       hs, vs, cs, de, fs;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        video_timing_gen #(
            .H_ACTIVE(P_HA[g]), .H_FP(P_HFP[g]), .H_SYNC(P_HS[g]), .H_BP(P_HBP[g]),
            .V_ACTIVE(P_VA[g]), .V_FP(P_VFP[g]), .V_SYNC(P_VS[g]), .V_BP(P_VBP[g]),
            .HS_POL(P_HSP[g]), .VS_POL(P_VSP[g])
        ) u_dut (
            .clk(clk), .reset(reset), .ce_pix(ce_pix), .pattern_sel(pattern_sel),
            .hcnt(hc[g]), .vcnt(vc[g]), .hsync(hs[g]), .vsync(vs[g]), .csync(cs[g]),
            .de(de[g]), .dout(dout[g]), .frame_start(fs[g])
        );
    end

    function automatic int ht(int k);
        return P_HA[k] + P_HFP[k] + P_HS[k] + P_HBP[k];
    endfunction

    function automatic int vt(int k);
        return P_VA[k] + P_VFP[k] + P_VS[k] + P_VBP[k];
    endfunction

    function automatic logic [23:0] f_pix(int k, int h, int v, logic [1:0] pat);
        int idx;
        if (!(h < P_HA[k] && v < P_VA[k])) return 24'h0;
        case (pat)
            2'd1: begin
                idx = h / (P_HA[k] / 8);
                if (idx > 7) idx = 7;
                return BARS[idx];
            end
            2'd2: return ((h % 16) == 0 || (v % 16) == 0) ? 24'hFFFFFF : 24'h0;
            2'd3: return {8'(h % 256), 8'(v % 256), 8'((h % 256) ^ (v % 256))};
            default: return 24'h0;
        endcase
    endfunction

    // Reference model: raster position as a linear pixel index modulo the frame size.
    int         mh [3];
    int         mv [3];
    logic [1:0] mpat [3];
    logic       mfs [3];

    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (reset) begin
                mh[k]   <= ht(k) - 1;
                mv[k]   <= vt(k) - 1;
                mpat[k] <= 2'd0;
                mfs[k]  <= 1'b0;
            end else if (ce_pix) begin
                automatic int p;
                p = (mv[k] * ht(k) + mh[k] + 1) % (ht(k) * vt(k));
                mh[k]  <= p % ht(k);
                mv[k]  <= p / ht(k);
                mfs[k] <= (p == 0);
                if (p == 0) mpat[k] <= pattern_sel;
            end else begin
                mfs[k] <= 1'b0;
            end
        end
    end

    task automatic pulse_reset();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; ce_pix = 1'b1; pattern_sel = 2'd2;
        @(negedge clk);
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            total++;
            if ({hc[k], vc[k], de[k], hs[k], vs[k], cs[k], fs[k], dout[k]} !==
                {12'(ht(k) - 1), 12'(vt(k) - 1), 1'b0, !P_HSP[k], !P_VSP[k], 1'b1, 1'b0, 24'h0}) begin
                bad++;
                $display("FAIL reset_state[%0d]: got h=%0d v=%0d de=%b hs=%b vs=%b cs=%b fs=%b dout=%h", k,
                         hc[k], vc[k], de[k], hs[k], vs[k], cs[k], fs[k], dout[k]);
            end
        end
    endtask

    task automatic test_first_line();
        pattern_sel = 2'd1; ce_pix = 1'b1; reset = 1'b0;
        for (int i = 0; i < 800; i++) begin
            @(negedge clk);
            total++;
            if (hc[0] !== 12'(i) || vc[0] !== 12'd0) begin
                bad++;
                $display("FAIL line_count: got h=%0d v=%0d want h=%0d v=0", hc[0], vc[0], i);
            end
            if (i == 0) begin
                total++;
                if ({de[0], fs[0], dout[0]} !== {1'b1, 1'b1, 24'hFFFFFF}) begin
                    bad++;
                    $display("FAIL first_pixel: got de=%b fs=%b dout=%h want 1 1 ffffff", de[0], fs[0], dout[0]);
                end
            end
            if (i == 1) begin
                total++;
                if (fs[0] !== 1'b0) begin bad++; $display("FAIL fs_width: got %b want 0", fs[0]); end
            end
            if (i == 80) begin
                total++;
                if (dout[0] !== 24'hFFFF00) begin bad++; $display("FAIL bar1: got %h want ffff00", dout[0]); end
            end
            if (i == 639) begin
                total++;
                if ({de[0], dout[0]} !== {1'b1, 24'h0}) begin
                    bad++; $display("FAIL bar7: got de=%b dout=%h want 1 000000", de[0], dout[0]);
                end
            end
            if (i == 640) begin
                total++;
                if ({de[0], dout[0]} !== {1'b0, 24'h0}) begin
                    bad++; $display("FAIL de_end: got de=%b dout=%h want 0 000000", de[0], dout[0]);
                end
            end
            if (i == 655 || i == 656 || i == 751 || i == 752) begin
                total++;
                if (hs[0] !== ((i == 655 || i == 752) ? 1'b1 : 1'b0)) begin
                    bad++; $display("FAIL hsync_edge: at h=%0d got %b", i, hs[0]);
                end
            end
        end
    endtask

    task automatic test_frame();
        int   last_fs;
        int   npulse;
        int   nwrap;
        logic prev_vs2;
        logic [11:0] prev_vc1;
        logic e_hs, e_vs, e_cs;
        last_fs = -1; npulse = 0; nwrap = 0;
        ce_pix = 1'b1;
        pulse_reset();
        prev_vs2 = vs[2];
        prev_vc1 = vc[1];
        for (int c = 0; c < 5700; c++) begin
            @(negedge clk);
            if (fs[2]) begin
                if (last_fs >= 0) begin
                    total++;
                    if (c - last_fs != 720) begin
                        bad++; $display("FAIL frame_period: got %0d want 720", c - last_fs);
                    end
                end
                last_fs = c;
                npulse++;
            end
            if (vc[2] == 12'd10 || vc[2] == 12'd0) begin
                e_cs = (hc[2] >= 36 && hc[2] <= 43);
                if (vc[2] == 12'd0) e_cs = !e_cs;
                total++;
                if (cs[2] !== e_cs) begin
                    bad++; $display("FAIL csync_small: at h=%0d v=%0d got %b want %b", hc[2], vc[2], cs[2], e_cs);
                end
            end
            if (vs[2] !== prev_vs2) begin
                total++;
                if (hc[2] !== 12'd0 || vc[2] !== (vs[2] ? 12'd12 : 12'd10)) begin
                    bad++; $display("FAIL vsync_edge: vs=%b at h=%0d v=%0d", vs[2], hc[2], vc[2]);
                end
            end
            // Active-high configuration: syncs high while active, csync stays active-low.
            e_hs = (hc[1] >= 656 && hc[1] <= 751);
            e_vs = (vc[1] == 12'd5);
            e_cs = !(e_hs ^ e_vs);
            total++;
            if ({hs[1], vs[1], cs[1]} !== {e_hs, e_vs, e_cs}) begin
                bad++;
                $display("FAIL pol_high: at h=%0d v=%0d got %b%b%b want %b%b%b", hc[1], vc[1],
                         hs[1], vs[1], cs[1], e_hs, e_vs, e_cs);
            end
            if (prev_vc1 == 12'd6 && vc[1] != 12'd6) begin
                nwrap++;
                total++;
                if (vc[1] !== 12'd0 || hc[1] !== 12'd0) begin
                    bad++; $display("FAIL v_wrap: got h=%0d v=%0d want 0 0", hc[1], vc[1]);
                end
            end
            prev_vs2 = vs[2];
            prev_vc1 = vc[1];
        end
        total++;
        if (npulse < 2 || nwrap < 2) begin
            bad++; $display("FAIL frame_timeout: pulses=%0d wraps=%0d want >=2", npulse, nwrap);
        end
    endtask

    task automatic test_ce_quarter();
        logic [51:0] snap;
        bit sw, after, done_bar, done_grad;
        sw = 0; after = 0; done_bar = 0; done_grad = 0;
        pattern_sel = 2'd1;
        ce_pix = 1'b1;
        pulse_reset();
        for (int c = 0; c < 7000 && !done_grad; c++) begin
            ce_pix = ((c % 4) == 0);
            snap = {hc[2], vc[2], de[2], hs[2], vs[2], cs[2], dout[2]};
            @(negedge clk);
            if (!ce_pix) begin
                total++;
                if ({hc[2], vc[2], de[2], hs[2], vs[2], cs[2], dout[2], fs[2]} !== {snap, 1'b0}) begin
                    bad++;
                    $display("FAIL hold: got %h fs=%b want %h fs=0",
                             {hc[2], vc[2], de[2], hs[2], vs[2], cs[2], dout[2]}, fs[2], snap);
                end
            end else begin
                if (sw && fs[2]) after = 1;
                if (sw && !after && !done_bar && hc[2] == 12'd5 && vc[2] == 12'd5) begin
                    done_bar = 1;
                    total++;
                    if (dout[2] !== 24'hFFFF00) begin
                        bad++; $display("FAIL pat_hold: got %h want ffff00", dout[2]);
                    end
                end
                if (after && hc[2] == 12'd5 && vc[2] == 12'd3) begin
                    done_grad = 1;
                    total++;
                    if (dout[2] !== 24'h050306) begin
                        bad++; $display("FAIL pat_switch: got %h want 050306", dout[2]);
                    end
                end
            end
            if (!sw && vc[2] == 12'd3) begin
                pattern_sel = 2'd3;
                sw = 1;
            end
        end
        total++;
        if (!done_bar || !done_grad) begin
            bad++; $display("FAIL ce_timeout: bar=%0d grad=%0d want 1 1", done_bar, done_grad);
        end
    endtask

    task automatic test_reset_mid();
        bit hit;
        hit = 0;
        ce_pix = 1'b1;
        pulse_reset();
        for (int c = 0; c < 1000 && !hit; c++) begin
            @(negedge clk);
            if (hc[2] == 12'd20 && vc[2] == 12'd5) hit = 1;
        end
        total++;
        if (!hit) begin bad++; $display("FAIL mid_timeout: got 0 want 1"); end
        ce_pix = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        total++;
        if ({hc[2], vc[2], de[2], dout[2], cs[2], hs[2], vs[2], fs[2]} !==
            {12'd47, 12'd14, 1'b0, 24'h0, 1'b1, 1'b1, 1'b1, 1'b0}) begin
            bad++;
            $display("FAIL mid_reset2: got h=%0d v=%0d de=%b dout=%h cs=%b hs=%b vs=%b",
                     hc[2], vc[2], de[2], dout[2], cs[2], hs[2], vs[2]);
        end
        total++;
        if ({hc[0], vc[0], de[0], dout[0], cs[0], hs[1], vs[1]} !==
            {12'd799, 12'd524, 1'b0, 24'h0, 1'b1, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL mid_reset0: got h=%0d v=%0d de=%b dout=%h cs=%b hs1=%b vs1=%b",
                     hc[0], vc[0], de[0], dout[0], cs[0], hs[1], vs[1]);
        end
        reset = 1'b0;
    endtask

    task automatic test_random();
        logic [52:0] got, want;
        logic hsa, vsa;
        int nfail;
        nfail = 0;
        for (int c = 0; c < 15000 && nfail < 20; c++) begin
            reset  = ($urandom_range(0, 4999) == 0);
            ce_pix = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 199) == 0) pattern_sel = 2'($urandom_range(0, 3));
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                hsa  = (mh[k] >= P_HA[k] + P_HFP[k]) && (mh[k] < P_HA[k] + P_HFP[k] + P_HS[k]);
                vsa  = (mv[k] >= P_VA[k] + P_VFP[k]) && (mv[k] < P_VA[k] + P_VFP[k] + P_VS[k]);
                want = {12'(mh[k]), 12'(mv[k]), (mh[k] < P_HA[k] && mv[k] < P_VA[k]),
                        hsa ^ !P_HSP[k], vsa ^ !P_VSP[k], !(hsa ^ vsa), mfs[k],
                        f_pix(k, mh[k], mv[k], mpat[k])};
                got  = {hc[k], vc[k], de[k], hs[k], vs[k], cs[k], fs[k], dout[k]};
                total++;
                if (got !== want) begin
                    bad++;
                    nfail++;
                    $display("FAIL random[%0d]: got %h want %h", k, got, want);
                end
            end
        end
        reset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_first_line();
        test_frame();
        test_ce_quarter();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
